// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle control unit: fetch/decode/exec/mem/wb sequencer
// with retire counter, sticky illegal-opcode and memory-timeout flags.
module control_unit #(
  parameter int OPCODE_WIDTH = 6,
  parameter int CNT_WIDTH    = 32,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic                    c_clk,
  input  logic                    c_rst,
  input  logic                    c_i_en,
  input  logic [OPCODE_WIDTH-1:0] c_i_opcode,
  input  logic                    c_i_mem_ready,
  output logic                    c_o_ce,
  output logic                    c_o_RegDst,
  output logic                    c_o_RegWrite,
  output logic                    c_o_ALUSrc,
  output logic                    c_o_Branch,
  output logic                    c_o_MemRead,
  output logic                    c_o_MemWrite,
  output logic                    c_o_MemtoReg,
  output logic [2:0]              c_o_state,
  output logic                    c_o_instr_done,
  output logic [CNT_WIDTH-1:0]    c_o_instr_cnt,
  output logic                    c_o_illegal,
  output logic                    c_o_mem_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } state_t;

  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [OPCODE_WIDTH-1:0] OP_R    = OPCODE_WIDTH'(6'h00);
  localparam logic [OPCODE_WIDTH-1:0] OP_LW   = OPCODE_WIDTH'(6'h23);
  localparam logic [OPCODE_WIDTH-1:0] OP_SW   = OPCODE_WIDTH'(6'h2B);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = OPCODE_WIDTH'(6'h04);
  localparam logic [OPCODE_WIDTH-1:0] OP_BNE  = OPCODE_WIDTH'(6'h05);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(6'h08);
  localparam logic [OPCODE_WIDTH-1:0] OP_SLTI = OPCODE_WIDTH'(6'h0A);
  localparam logic [OPCODE_WIDTH-1:0] OP_ANDI = OPCODE_WIDTH'(6'h0C);
  localparam logic [OPCODE_WIDTH-1:0] OP_ORI  = OPCODE_WIDTH'(6'h0D);

  function automatic logic is_ialu(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

  function automatic logic is_mem(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic is_branch(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  function automatic logic is_legal(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_R) || is_mem(op) || is_branch(op) || is_ialu(op);
  endfunction

  state_t                  state, next_state, end_state;
  logic [OPCODE_WIDTH-1:0] opc, next_opc;
  logic [WW-1:0]           wait_cnt, next_wait;
  logic                    retire, set_illegal, set_mem_err;

  always_comb begin
    next_state  = state;
    next_opc    = opc;
    next_wait   = wait_cnt;
    retire      = 1'b0;
    set_illegal = 1'b0;
    set_mem_err = 1'b0;
    end_state   = c_i_en ? FETCH : IDLE;
    case (state)
      IDLE:   if (c_i_en) next_state = FETCH;
      FETCH:  next_state = DECODE;
      DECODE: begin
        next_opc = c_i_opcode;
        if (is_legal(c_i_opcode)) begin
          next_state = EXEC;
        end else begin
          set_illegal = 1'b1;
          next_state  = end_state;
        end
      end
      EXEC: begin
        if (is_mem(opc)) begin
          next_state = MEM;
          next_wait  = '0;
        end else if (is_branch(opc)) begin
          retire     = 1'b1;
          next_state = end_state;
        end else begin
          next_state = WB;
        end
      end
      MEM: begin
        // ready takes priority over a timeout landing in the same cycle
        if (c_i_mem_ready) begin
          if (opc == OP_LW) begin
            next_state = WB;
          end else begin
            retire     = 1'b1;
            next_state = end_state;
          end
        end else if (wait_cnt == WW'(MEM_TIMEOUT - 1)) begin
          set_mem_err = 1'b1;
          next_state  = end_state;
        end else begin
          next_wait = wait_cnt + WW'(1);
        end
      end
      WB: begin
        retire     = 1'b1;
        next_state = end_state;
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from the next state/opcode so they line up with the state they describe.
  always_ff @(posedge c_clk or posedge c_rst) begin
    if (c_rst) begin
      state          <= IDLE;
      opc            <= '0;
      wait_cnt       <= '0;
      c_o_ce         <= 1'b0;
      c_o_RegDst     <= 1'b0;
      c_o_RegWrite   <= 1'b0;
      c_o_ALUSrc     <= 1'b0;
      c_o_Branch     <= 1'b0;
      c_o_MemRead    <= 1'b0;
      c_o_MemWrite   <= 1'b0;
      c_o_MemtoReg   <= 1'b0;
      c_o_instr_done <= 1'b0;
      c_o_instr_cnt  <= '0;
      c_o_illegal    <= 1'b0;
      c_o_mem_err    <= 1'b0;
    end else begin
      state          <= next_state;
      opc            <= next_opc;
      wait_cnt       <= next_wait;
      c_o_ce         <= (next_state == FETCH);
      c_o_ALUSrc     <= ((next_state == EXEC) || (next_state == MEM) || (next_state == WB))
                        && (is_mem(next_opc) || is_ialu(next_opc));
      c_o_Branch     <= (next_state == EXEC) && is_branch(next_opc);
      c_o_MemRead    <= (next_state == MEM) && (next_opc == OP_LW);
      c_o_MemWrite   <= (next_state == MEM) && (next_opc == OP_SW);
      c_o_RegWrite   <= (next_state == WB);
      c_o_RegDst     <= (next_state == WB) && (next_opc == OP_R);
      c_o_MemtoReg   <= (next_state == WB) && (next_opc == OP_LW);
      c_o_instr_done <= retire;
      if (retire) c_o_instr_cnt <= c_o_instr_cnt + CNT_WIDTH'(1);
      if (set_illegal) c_o_illegal <= 1'b1;
      if (set_mem_err) c_o_mem_err <= 1'b1;
    end
  end

  assign c_o_state = state;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench for control_unit
module tb_control_unit;

  logic       c_clk, c_rst, c_i_en, c_i_mem_ready;
  logic [5:0] c_i_opcode;
  logic       c_o_ce, c_o_RegDst, c_o_RegWrite, c_o_ALUSrc, c_o_Branch;
  logic       c_o_MemRead, c_o_MemWrite, c_o_MemtoReg;
  logic [2:0] c_o_state;
  logic       c_o_instr_done, c_o_illegal, c_o_mem_err;
  logic [3:0] c_o_instr_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [3:0] exp_cnt = 4'd0;

  control_unit #(.OPCODE_WIDTH(6), .CNT_WIDTH(4), .MEM_TIMEOUT(15)) dut (
    .c_clk(c_clk), .c_rst(c_rst), .c_i_en(c_i_en), .c_i_opcode(c_i_opcode),
    .c_i_mem_ready(c_i_mem_ready), .c_o_ce(c_o_ce), .c_o_RegDst(c_o_RegDst),
    .c_o_RegWrite(c_o_RegWrite), .c_o_ALUSrc(c_o_ALUSrc), .c_o_Branch(c_o_Branch),
    .c_o_MemRead(c_o_MemRead), .c_o_MemWrite(c_o_MemWrite), .c_o_MemtoReg(c_o_MemtoReg),
    .c_o_state(c_o_state), .c_o_instr_done(c_o_instr_done), .c_o_instr_cnt(c_o_instr_cnt),
    .c_o_illegal(c_o_illegal), .c_o_mem_err(c_o_mem_err)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  // {state, ce, RegDst, RegWrite, ALUSrc, Branch, MemRead, MemWrite, MemtoReg, done}
  wire [11:0] snap = {c_o_state, c_o_ce, c_o_RegDst, c_o_RegWrite, c_o_ALUSrc, c_o_Branch,
                      c_o_MemRead, c_o_MemWrite, c_o_MemtoReg, c_o_instr_done};

  function automatic logic [11:0] ex(input logic [2:0] s, input logic ce,
                                     input logic [6:0] ctl, input logic done);
    return {s, ce, ctl, done};
  endfunction

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_ALU  = 7'b0010000;
  localparam logic [6:0] C_BR   = 7'b0001000;
  localparam logic [6:0] C_RWB  = 7'b1100000;
  localparam logic [6:0] C_LWM  = 7'b0010100;
  localparam logic [6:0] C_LWB  = 7'b0110001;
  localparam logic [6:0] C_SWM  = 7'b0010010;

  task automatic step();
    @(negedge c_clk);
  endtask

  task automatic test_reset();
    c_rst = 1'b1; c_i_en = 1'b0; c_i_opcode = 6'h00; c_i_mem_ready = 1'b0;
    step(); step();
    total_cnt++;
    if (snap !== 12'h000) $display("FAIL reset_snap: got %h want %h", snap, 12'h000); else pass_cnt++;
    total_cnt++;
    if ({c_o_instr_cnt, c_o_illegal, c_o_mem_err} !== 6'b0)
      $display("FAIL reset_flags: got cnt=%0d ill=%b err=%b want 0", c_o_instr_cnt, c_o_illegal, c_o_mem_err);
    else pass_cnt++;
    c_rst = 1'b0;
    step(); step();
    total_cnt++;
    if (snap !== 12'h000) $display("FAIL idle_hold: got %h want %h", snap, 12'h000); else pass_cnt++;
  endtask

  task automatic test_r_type();
    logic [11:0] e [5];
    e = '{ex(1,1,C_NONE,0), ex(2,0,C_NONE,0), ex(3,0,C_NONE,0), ex(5,0,C_RWB,0), ex(0,0,C_NONE,1)};
    c_i_en = 1'b1; c_i_opcode = 6'h00;
    for (int i = 0; i < 5; i++) begin
      step();
      total_cnt++;
      if (snap !== e[i]) $display("FAIL r_type cyc%0d: got %h want %h", i, snap, e[i]); else pass_cnt++;
      c_i_en = 1'b0;
    end
    exp_cnt++;
    total_cnt++;
    if (c_o_instr_cnt !== exp_cnt) $display("FAIL r_type_cnt: got %0d want %0d", c_o_instr_cnt, exp_cnt); else pass_cnt++;
  endtask

  task automatic test_lw_wait();
    logic [11:0] e [9];
    e = '{ex(1,1,C_NONE,0), ex(2,0,C_NONE,0), ex(3,0,C_ALU,0), ex(4,0,C_LWM,0), ex(4,0,C_LWM,0),
          ex(4,0,C_LWM,0), ex(4,0,C_LWM,0), ex(5,0,C_LWB,0), ex(0,0,C_NONE,1)};
    c_i_en = 1'b1; c_i_opcode = 6'h23; c_i_mem_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      total_cnt++;
      if (snap !== e[i]) $display("FAIL lw_wait cyc%0d: got %h want %h", i, snap, e[i]); else pass_cnt++;
      c_i_en = 1'b0;
      c_i_mem_ready = (i == 6);
    end
    exp_cnt++;
    total_cnt++;
    if (c_o_instr_cnt !== exp_cnt) $display("FAIL lw_cnt: got %0d want %0d", c_o_instr_cnt, exp_cnt); else pass_cnt++;
  endtask

  task automatic test_ready_at_timeout();
    logic [11:0] e;
    c_i_en = 1'b1; c_i_opcode = 6'h2B; c_i_mem_ready = 1'b0;
    for (int i = 0; i < 19; i++) begin
      step();
      e = (i == 0) ? ex(1,1,C_NONE,0) : (i == 1) ? ex(2,0,C_NONE,0) : (i == 2) ? ex(3,0,C_ALU,0) :
          (i < 18) ? ex(4,0,C_SWM,0) : ex(0,0,C_NONE,1);
      total_cnt++;
      if (snap !== e) $display("FAIL sw_ready_edge cyc%0d: got %h want %h", i, snap, e); else pass_cnt++;
      c_i_en = 1'b0;
      c_i_mem_ready = (i == 17);
    end
    exp_cnt++;
    total_cnt++;
    if ({c_o_mem_err, c_o_instr_cnt} !== {1'b0, exp_cnt})
      $display("FAIL sw_ready_edge_end: got err=%b cnt=%0d want err=0 cnt=%0d", c_o_mem_err, c_o_instr_cnt, exp_cnt);
    else pass_cnt++;
  endtask

  task automatic test_mem_timeout();
    logic [11:0] e;
    c_i_en = 1'b1; c_i_opcode = 6'h2B; c_i_mem_ready = 1'b0;
    for (int i = 0; i < 22; i++) begin
      step();
      e = (i == 0) ? ex(1,1,C_NONE,0) : (i == 1) ? ex(2,0,C_NONE,0) : (i == 2) ? ex(3,0,C_ALU,0) :
          (i < 18) ? ex(4,0,C_SWM,0) : (i == 18) ? ex(1,1,C_NONE,0) : (i == 19) ? ex(2,0,C_NONE,0) :
          (i == 20) ? ex(3,0,C_BR,0) : ex(0,0,C_NONE,1);
      total_cnt++;
      if (snap !== e) $display("FAIL sw_timeout cyc%0d: got %h want %h", i, snap, e); else pass_cnt++;
      if (i == 17 || i == 18) begin
        total_cnt++;
        if (c_o_mem_err !== (i == 18)) $display("FAIL mem_err cyc%0d: got %b want %b", i, c_o_mem_err, i == 18);
        else pass_cnt++;
      end
      if (i == 18) begin c_i_en = 1'b0; c_i_opcode = 6'h04; end
    end
    exp_cnt++;
    total_cnt++;
    if (c_o_instr_cnt !== exp_cnt) $display("FAIL timeout_cnt: got %0d want %0d", c_o_instr_cnt, exp_cnt); else pass_cnt++;
  endtask

  task automatic test_illegal();
    logic [11:0] e [3];
    e = '{ex(1,1,C_NONE,0), ex(2,0,C_NONE,0), ex(0,0,C_NONE,0)};
    c_i_en = 1'b1; c_i_opcode = 6'h3F;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++;
      if (snap !== e[i]) $display("FAIL illegal cyc%0d: got %h want %h", i, snap, e[i]); else pass_cnt++;
      c_i_en = 1'b0;
    end
    total_cnt++;
    if ({c_o_illegal, c_o_instr_cnt} !== {1'b1, exp_cnt})
      $display("FAIL illegal_flag: got ill=%b cnt=%0d want ill=1 cnt=%0d", c_o_illegal, c_o_instr_cnt, exp_cnt);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [11:0] e [7];
    e = '{ex(1,1,C_NONE,0), ex(2,0,C_NONE,0), ex(3,0,C_BR,0), ex(1,1,C_NONE,1),
          ex(2,0,C_NONE,0), ex(3,0,C_BR,0), ex(0,0,C_NONE,1)};
    c_i_en = 1'b1; c_i_opcode = 6'h04;
    for (int i = 0; i < 7; i++) begin
      step();
      total_cnt++;
      if (snap !== e[i]) $display("FAIL back_to_back cyc%0d: got %h want %h", i, snap, e[i]); else pass_cnt++;
      if (i == 3) c_i_opcode = 6'h05;
      if (i == 5) c_i_en = 1'b0;
    end
    exp_cnt = exp_cnt + 4'd2;
    total_cnt++;
    if ({c_o_illegal, c_o_instr_cnt} !== {1'b1, exp_cnt})
      $display("FAIL b2b_end: got ill=%b cnt=%0d want ill=1 cnt=%0d", c_o_illegal, c_o_instr_cnt, exp_cnt);
    else pass_cnt++;
  endtask

  task automatic test_cnt_wrap();
    c_i_opcode = 6'h05;
    for (int n = 0; n < 16; n++) begin
      c_i_en = 1'b1;
      step();
      c_i_en = 1'b0;
      step(); step(); step();
      exp_cnt++;
      total_cnt++;
      if ({c_o_instr_done, c_o_instr_cnt} !== {1'b1, exp_cnt})
        $display("FAIL cnt_wrap it%0d: got done=%b cnt=%0d want done=1 cnt=%0d", n, c_o_instr_done, c_o_instr_cnt, exp_cnt);
      else pass_cnt++;
      if (exp_cnt == 4'd0) break;
    end
    total_cnt++;
    if (c_o_instr_cnt !== 4'd0) $display("FAIL cnt_zero: got %0d want 0", c_o_instr_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid_mem();
    c_i_en = 1'b1; c_i_opcode = 6'h23; c_i_mem_ready = 1'b0;
    step(); c_i_en = 1'b0;
    step(); step(); step();
    total_cnt++;
    if (snap !== ex(4,0,C_LWM,0)) $display("FAIL pre_rst_mem: got %h want %h", snap, ex(4,0,C_LWM,0)); else pass_cnt++;
    #2 c_rst = 1'b1;
    #1;
    total_cnt++;
    if ({snap, c_o_instr_cnt, c_o_illegal, c_o_mem_err} !== 18'b0)
      $display("FAIL async_rst: got snap=%h cnt=%0d ill=%b err=%b want all 0", snap, c_o_instr_cnt, c_o_illegal, c_o_mem_err);
    else pass_cnt++;
    step();
    c_rst = 1'b0;
    c_i_mem_ready = 1'b1;
    step();
    total_cnt++;
    if ({snap, c_o_instr_cnt} !== 16'b0) $display("FAIL post_rst_idle: got %h want 0", {snap, c_o_instr_cnt}); else pass_cnt++;
    c_i_mem_ready = 1'b0;
    c_i_en = 1'b1;
    step();
    total_cnt++;
    if (snap !== ex(1,1,C_NONE,0)) $display("FAIL post_rst_fetch: got %h want %h", snap, ex(1,1,C_NONE,0)); else pass_cnt++;
    c_i_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_lw_wait();
    test_ready_at_timeout();
    test_mem_timeout();
    test_illegal();
    test_back_to_back();
    test_cnt_wrap();
    test_reset_mid_mem();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter OPCODE_WIDTH, default 6, opcode field width.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, retired-instruction counter width.
REQ-003 SHALL have parameter MEM_TIMEOUT, default 15, max cycles waiting in MEM for c_i_mem_ready.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: c_clk  in  1  rising-edge clock; c_rst  in  1  async active-high reset.
REQ-005 SHALL have the remaining ports:
- c_i_en  in  1  run enable; sampled only in IDLE and at instruction end.
- c_i_opcode  in  OPCODE_WIDTH  opcode from decoder stage.
- c_i_mem_ready  in  1  data memory access complete.
- c_o_ce  out  1  fetch enable to the datapath.
- c_o_RegDst, c_o_RegWrite, c_o_ALUSrc, c_o_Branch, c_o_MemRead, c_o_MemWrite, c_o_MemtoReg  out  1 each  datapath controls.
- c_o_state  out  3  current state encoding.
- c_o_instr_done  out  1  one-cycle pulse per retired instruction.
- c_o_instr_cnt  out  CNT_WIDTH  retired-instruction count.
- c_o_illegal  out  1  sticky illegal-opcode flag.
- c_o_mem_err  out  1  sticky memory-timeout flag.

Function
REQ-006 SHALL implement the states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5; codes 6-7 SHALL go to IDLE on the next cycle.
REQ-007 Transition IDLE->FETCH SHALL occur when c_i_en=1; otherwise the FSM SHALL stay in IDLE.
REQ-008 FETCH->DECODE SHALL be unconditional; c_o_ce=1 only in FETCH.
REQ-009 In DECODE the FSM SHALL latch c_i_opcode into an internal opcode register and go to EXEC.
REQ-010 Decoded classes: R=0x00, LW=0x23, SW=0x2B, BEQ=0x04, BNE=0x05, IALU={0x08,0x0A,0x0C,0x0D}; any other value is illegal.
REQ-011 An illegal opcode SHALL set c_o_illegal in DECODE, assert no control outputs, and end the instruction without retiring it.
REQ-012 From EXEC the FSM SHALL go to MEM for LW and SW, to WB for R and IALU, and end the instruction for BEQ and BNE.
REQ-013 In MEM the FSM SHALL stay until c_i_mem_ready=1, then go to WB for LW and end the instruction for SW.
REQ-014 In MEM a wait counter SHALL count cycles; when it reaches MEM_TIMEOUT with c_i_mem_ready=0, the FSM SHALL set c_o_mem_err and end the instruction without retiring it.
REQ-015 The wait counter SHALL clear on MEM entry.
REQ-016 Control outputs SHALL be Moore outputs, decoded from the state and the latched opcode:
- ALUSrc=1 in EXEC, MEM and WB for LW, SW and IALU.
- Branch=1 in EXEC for BEQ and BNE.
- MemRead=1 in MEM for LW.
- MemWrite=1 in MEM for SW.
- RegWrite=1 in WB.
- RegDst=1 in WB for R.
- MemtoReg=1 in WB for LW.
- All other cases 0.
REQ-017 At instruction end the next state SHALL be FETCH if c_i_en=1, else IDLE.
REQ-018 At retire, c_o_instr_done SHALL pulse for one cycle and c_o_instr_cnt SHALL increment in the same cycle. Retire points: WB exit, BEQ/BNE EXEC exit, SW MEM exit.
REQ-019 c_o_instr_cnt SHALL wrap from all-ones to 0.
REQ-020 c_i_en=0 mid-instruction SHALL NOT abort the instruction.
REQ-021 Latencies from FETCH entry to done pulse, with zero memory wait: BEQ/BNE 3 cycles, R/IALU/SW 4 cycles, LW 5 cycles.
REQ-022 If c_i_mem_ready=1 arrives in the same cycle as the timeout, ready SHALL win: no error, normal completion.

Reset
REQ-023 c_rst=1 SHALL immediately force: state IDLE, opcode register 0, wait counter 0, c_o_instr_cnt 0, c_o_illegal 0, c_o_mem_err 0, and all control outputs, c_o_ce and c_o_instr_done to 0.
REQ-024 Reset asserted mid-instruction SHALL discard that instruction with no retire.
REQ-025 After reset deassertion, FETCH SHALL be entered on the first edge with c_i_en=1.

Verification
REQ-026 R-type: en=1, opcode 0x00 -> states 1,2,3,5; RegWrite=1 and RegDst=1 in WB; done at cycle 4; instr_cnt=1.
REQ-027 LW with mem_ready delayed 3 cycles: MEM held 4 cycles with MemRead=1, then WB with MemtoReg=1 and RegWrite=1; instr_cnt increments once.
REQ-028 SW with mem_ready never asserted: after 15 MEM cycles mem_err=1, no done pulse, next state FETCH (en=1); MemWrite was 1 throughout MEM.
REQ-029 Opcode 0x3F: illegal=1 after DECODE, no control outputs asserted, instr_cnt unchanged; flag cleared only by reset.
REQ-030 Back-to-back BEQ with en=1: done pulse every 3 cycles, Branch=1 only in EXEC; en dropped mid-EXEC -> instruction completes, then IDLE.
REQ-031 Preload instr_cnt to all-ones via forced retires, retire once more -> 0. Assert c_rst during MEM -> all outputs 0 within the same cycle, state 0.
